// File: rtl/div32_restoring.sv
// div32_restoring
// ---------------
// Sequential unsigned restoring divider that produces one quotient bit per
// clock. The CPU's multi-cycle divide path raises i_start, stalls while
// o_busy is high, and captures o_quotient/o_remainder when o_done pulses.
//
// Optional feature macro: DIV_SIGNED_EN
//   Defined   -> operands are two's complement. Magnitudes are divided, and
//                the signs are fixed up when the result is registered.
//   Undefined -> unsigned only, and no sign logic is built.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_start        request a divide (accepted in IDLE or FIN)
//   i_dividend     numerator, sampled on the accepting edge
//   i_divisor      denominator, sampled on the accepting edge
//   o_busy         high while iterating
//   o_done         one-cycle pulse; results valid
//   o_quotient     registered quotient, held until the next result
//   o_remainder    registered remainder, held until the next result
//   o_div_by_zero  registered divide-by-zero flag for the last operation

module div32_restoring #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int RW = 2*WIDTH + 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [RW-1:0]    r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_count;
    logic             r_zeroPending;

    logic [WIDTH:0]   w_trial;
    logic [RW-1:0]    w_next;
    logic [WIDTH-1:0] w_quotFinal;
    logic [WIDTH-1:0] w_remFinal;
    logic [WIDTH-1:0] w_dividendMag;
    logic [WIDTH-1:0] w_divisorMag;
    logic             w_canAccept;
    logic             w_unusedTop;

    // The top bit of the partial remainder is always zero after a step,
    // because the remainder never reaches the divisor. It is kept only so
    // that the register is the full 2*WIDTH+1 bits wide.
    assign w_unusedTop = r_rem[RW-1];

    // One restoring step. The shifted remainder S = R << 1 is read directly
    // out of r_rem one bit lower, so S[64:32] is r_rem[63:31]. A clear
    // borrow bit keeps the difference and shifts in a 1. Otherwise the
    // shifted value is restored and a 0 is shifted in.
    assign w_trial = r_rem[2*WIDTH-1:WIDTH-1] - {1'b0, r_divisor};
    assign w_next  = w_trial[WIDTH] ? {r_rem[2*WIDTH-1:0], 1'b0}
                                    : {w_trial, r_rem[WIDTH-2:0], 1'b1};

    // A pending divide-by-zero result must be written out before a new
    // request is accepted. Otherwise that result would be lost.
    assign w_canAccept = (r_state == IDLE) || ((r_state == FIN) && !r_zeroPending);

`ifdef DIV_SIGNED_EN
    logic r_negQ;
    logic r_negR;

    // Negating the most negative value gives back the same bit pattern.
    // Read as unsigned, that pattern is the correct magnitude, so no
    // special case is needed for the overflow operands.
    assign w_dividendMag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
    assign w_divisorMag  = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;
    assign w_quotFinal   = r_negQ ? -w_next[WIDTH-1:0]       : w_next[WIDTH-1:0];
    assign w_remFinal    = r_negR ? -w_next[2*WIDTH-1:WIDTH] : w_next[2*WIDTH-1:WIDTH];
`else
    assign w_dividendMag = i_dividend;
    assign w_divisorMag  = i_divisor;
    assign w_quotFinal   = w_next[WIDTH-1:0];
    assign w_remFinal    = w_next[2*WIDTH-1:WIDTH];
`endif

    // Control FSM and datapath registers. All outputs are registered here.
    // A zero divisor jumps straight to FIN with r_zeroPending set. The
    // following edge then publishes the divide-by-zero result, so o_done
    // arrives one cycle after the accepting edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_rem         <= '0;
            r_divisor     <= '0;
            r_count       <= '0;
            r_zeroPending <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_negQ        <= 1'b0;
            r_negR        <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE, FIN: begin
                    if (r_zeroPending) begin
                        o_quotient    <= '1;
                        o_remainder   <= r_rem[WIDTH-1:0];
                        o_div_by_zero <= 1'b1;
                        o_done        <= 1'b1;
                        r_zeroPending <= 1'b0;
                    end else if (i_start && w_canAccept) begin
                        r_count <= '0;
`ifdef DIV_SIGNED_EN
                        r_negQ  <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
                        r_negR  <= i_dividend[WIDTH-1];
`endif
                        if (i_divisor == '0) begin
                            r_divisor     <= '0;
                            r_rem         <= {{(WIDTH+1){1'b0}}, i_dividend};
                            r_zeroPending <= 1'b1;
                            r_state       <= FIN;
                        end else begin
                            r_divisor     <= w_divisorMag;
                            r_rem         <= {{(WIDTH+1){1'b0}}, w_dividendMag};
                            o_div_by_zero <= 1'b0;
                            o_busy        <= 1'b1;
                            r_state       <= RUN;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_rem   <= w_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH-1)) begin
                        o_quotient  <= w_quotFinal;
                        o_remainder <= w_remFinal;
                        o_done      <= 1'b1;
                        o_busy      <= 1'b0;
                        r_state     <= FIN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32_restoring.sv
// tb_div32_restoring
// ------------------
// Directed testbench for div32_restoring. The stimulus runs as a linear
// sequence of steps in one initial block. Expected values are worked out
// by hand, and outputs are sampled on the falling clock edge.

module tb_div32_restoring;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        divByZero;

   int checks = 0;
   int errors = 0;

   div32_restoring #(.WIDTH(32)) dut (
      .i_clk         (clock),
      .i_rst         (reset),
      .i_start       (start),
      .i_dividend    (dividend),
      .i_divisor     (divisor),
      .o_busy        (busy),
      .o_done        (done),
      .o_quotient    (quotient),
      .o_remainder   (remainder),
      .o_div_by_zero (divByZero)
   );

   // 10-time-unit clock. Rising edges fall at 5, 15, 25, ...
   always #5 clock = ~clock;

   // One comparison: count it, and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Hold start for one rising edge (the accepting edge), then scramble the
   // operands to show that later changes are ignored. The task returns on
   // the falling edge just after the accepting edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clock);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   // Wait for done, with a bound. Count falling edges after the accepting
   // edge, and the number of those samples that saw busy high.
   task automatic waitDone(output int cycles, output int busyCycles);
      cycles     = 0;
      busyCycles = busy ? 1 : 0;
      while (!done && cycles < 60) begin
         @(negedge clock);
         cycles++;
         if (busy) busyCycles++;
      end
   endtask

   // One complete operation, with checks on its result and timing.
   task automatic runCase(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expQ, input logic [31:0] expR,
                          input logic expDz, input int expCycles, input int expBusy);
      int cycles;
      int busyCycles;
      applyStimulus(a, b);
      waitDone(cycles, busyCycles);
      checkOutput({tag, "_latency"}, 32'(cycles), 32'(expCycles));
      checkOutput({tag, "_busyCycles"}, 32'(busyCycles), 32'(expBusy));
      checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
      checkOutput({tag, "_quotient"}, quotient, expQ);
      checkOutput({tag, "_remainder"}, remainder, expR);
      checkOutput({tag, "_divByZero"}, {31'b0, divByZero}, {31'b0, expDz});
      @(negedge clock);
      checkOutput({tag, "_donePulse"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      int cycles;
      int busyCycles;
      int extraDone;

      // Reset state. Outputs are checked while reset is still held.
      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      #12;
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_done", {31'b0, done}, 32'd0);
      checkOutput("rst_quotient", quotient, 32'd0);
      checkOutput("rst_remainder", remainder, 32'd0);
      checkOutput("rst_divByZero", {31'b0, divByZero}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Basic divide: the result arrives 32 falling-edge samples after
      // accept, with busy high for 32 cycles.
      runCase("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 32);

      // Boundary operands.
      runCase("max_1", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 32, 32);
      runCase("max_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32, 32);

      // Divide by zero: done one cycle after accept and busy never set.
      // The next nonzero divide then clears the flag.
      runCase("dz", 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1, 0);
      runCase("d10_3", 32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 32, 32);

      // A start pulse mid-RUN with other operands must be ignored.
      applyStimulus(32'd200, 32'd9);
      repeat (9) @(negedge clock);
      dividend = 32'd77;
      divisor  = 32'd5;
      start    = 1'b1;
      @(negedge clock);
      start    = 1'b0;
      waitDone(cycles, busyCycles);
      checkOutput("ignore_done", {31'b0, done}, 32'd1);
      checkOutput("ignore_quotient", quotient, 32'd22);
      checkOutput("ignore_remainder", remainder, 32'd2);
      extraDone = 0;
      repeat (40) begin
         @(negedge clock);
         if (done) extraDone++;
      end
      checkOutput("ignore_singleDone", 32'(extraDone), 32'd0);

      // Asynchronous reset mid-RUN clears everything, and no done follows.
      applyStimulus(32'd1000, 32'd3);
      repeat (5) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      checkOutput("arst_busy", {31'b0, busy}, 32'd0);
      checkOutput("arst_quotient", quotient, 32'd0);
      checkOutput("arst_remainder", remainder, 32'd0);
      checkOutput("arst_divByZero", {31'b0, divByZero}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      extraDone = 0;
      repeat (40) begin
         @(negedge clock);
         if (done) extraDone++;
      end
      checkOutput("arst_noDone", 32'(extraDone), 32'd0);
      runCase("d50_5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 32, 32);

`ifdef DIV_SIGNED_EN
      // Signed mode: sign fix-up and the overflow case.
      runCase("sneg7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 32, 32);
      runCase("sovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 32, 32);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
